// File: rtl/rr_arbiter_6.sv
// Six-way round-robin arbiter with a registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD hold limit and the TO_PULSE revocation strobe.
module rr_arbiter_6 #(
  parameter int MAX_HOLD = 16,
  parameter int HW       = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] REQ,
  output logic [5:0] GNT,
  output logic [2:0] GNT_ID,
  output logic       BUSY,
  output logic       TO_PULSE
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject illegal configurations at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 31 || (2 ** HW) <= (MAX_HOLD - 1)) begin : g_bad_cfg
    $error("rr_arbiter_6: MAX_HOLD must be 2..31 and 2**HW must exceed MAX_HOLD-1");
  end

  // Mod-6 increment: the pointer never takes the values 6 or 7.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd5) ? 3'd0 : v + 3'd1;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] gnt_q, gnt_d;
  logic [2:0] id_q, id_d;
  logic [2:0] ptr_q, ptr_d;

  logic       pick_valid;
  logic [2:0] pick_id;
  logic [2:0] scan_idx;
  logic       owner_req;
  logic       timeout_hit;
  logic       drop_grant;

  // Cyclic priority scan starting at the pointer.
  // NOTE: every variable written in an always_comb block gets a default on entry,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = ptr_q;
    scan_idx   = ptr_q;
    for (int k = 0; k < 6; k++) begin
      if (!pick_valid && REQ[scan_idx]) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign owner_req  = REQ[id_q];

`ifdef ARB_TIMEOUT_EN
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          to_q, to_d;

  assign timeout_hit = owner_req && (hcnt_q == HW'(MAX_HOLD - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // An owner release takes precedence over a coincident timeout.
  assign drop_grant = !owner_req || timeout_hit;

  // State register: also holds the registered outputs and the pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hcnt_q  <= hcnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (drop_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_d = gnt_q;
    id_d  = id_q;
    ptr_d = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hcnt_d = hcnt_q;
    to_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d = 6'b000001 << pick_id;
          id_d  = pick_id;
`ifdef ARB_TIMEOUT_EN
          hcnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (drop_grant) begin
          gnt_d = '0;
          ptr_d = wrap_inc(id_q);
`ifdef ARB_TIMEOUT_EN
          to_d  = owner_req;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hcnt_d = hcnt_q + HW'(1);
`endif
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign GNT    = gnt_q;
  assign GNT_ID = id_q;
  assign BUSY   = |gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign TO_PULSE = to_q;
`else
  assign TO_PULSE = 1'b0;
`endif

endmodule
